// File: rtl/game_flow_ctrl.sv
// Game sequencer: idle/ready/play/pause/death/over/win flow, lives tracking,
// movement gating and one-shot position/map reload requests.
module game_flow_ctrl #(
   parameter int unsigned LIVES        = 3,
   parameter int unsigned READY_FRAMES = 120,
   parameter int unsigned DEATH_FRAMES = 90
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       pause,
   input  logic       crash,
   input  logic       beans_done,
   output logic [2:0] state,
   output logic       run,
   output logic       pos_reload,
   output logic       map_reload,
   output logic [1:0] lives,
   output logic       over,
   output logic       win,
   output logic       flash
);

   localparam int unsigned CNT_W = 8;
   localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
   localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_FRAMES - 1);
   localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_DEATH = 3'd4,
      S_OVER  = 3'd5,
      S_WIN   = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       lives_q, lives_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             run_q, run_d;
   logic             pos_reload_q, pos_reload_d;
   logic             map_reload_q, map_reload_d;
   logic             over_q, over_d;
   logic             win_q, win_d;
   logic             flash_q, flash_d;
   logic             illegal;

   // Next-state, lives and reload decisions
   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      pos_reload_d = 1'b0;
      map_reload_d = 1'b0;
      illegal      = 1'b0;
      case (state_q)
         S_IDLE, S_OVER, S_WIN: begin
            if (start) begin
               state_d      = S_READY;
               lives_d      = LIVES_INIT;
               pos_reload_d = 1'b1;
               map_reload_d = 1'b1;
            end
         end
         S_READY: begin
            if (frame_tick && frame_cnt_q == READY_LAST) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (beans_done) begin
               state_d = S_WIN;
            end else if (crash) begin
               state_d = S_DEATH;
               lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            end else if (pause) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (pause) state_d = S_PLAY;
         end
         S_DEATH: begin
            if (frame_tick && frame_cnt_q == DEATH_LAST) begin
               if (lives_q == 2'd0) begin
                  state_d = S_OVER;
               end else begin
                  state_d      = S_READY;
                  pos_reload_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            lives_d = LIVES_INIT;
            illegal = 1'b1;
         end
      endcase

      // Counter restarts on any state entry and holds while paused
      frame_cnt_d = frame_cnt_q;
      if (illegal || state_d != state_q) begin
         frame_cnt_d = '0;
      end else if (frame_tick && state_q != S_PAUSE) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end

      run_d   = (state_d == S_PLAY);
      over_d  = (state_d == S_OVER);
      win_d   = (state_d == S_WIN);
      flash_d = ((state_d == S_READY) || (state_d == S_DEATH)) && frame_cnt_d[3];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         lives_q      <= LIVES_INIT;
         frame_cnt_q  <= '0;
         run_q        <= 1'b0;
         pos_reload_q <= 1'b0;
         map_reload_q <= 1'b0;
         over_q       <= 1'b0;
         win_q        <= 1'b0;
         flash_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         frame_cnt_q  <= frame_cnt_d;
         run_q        <= run_d;
         pos_reload_q <= pos_reload_d;
         map_reload_q <= map_reload_d;
         over_q       <= over_d;
         win_q        <= win_d;
         flash_q      <= flash_d;
      end
   end

   assign state      = state_q;
   assign lives      = lives_q;
   assign run        = run_q;
   assign pos_reload = pos_reload_q;
   assign map_reload = map_reload_q;
   assign over       = over_q;
   assign win        = win_q;
   assign flash      = flash_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized self-checking bench for game_flow_ctrl against a per-cycle
// behavioural model of the game rules, plus directed scenario pins.
module tb_game_flow_ctrl;

   localparam int RF = 120;
   localparam int DF = 90;
   localparam int NL = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0, start = 1'b0, pause = 1'b0, crash = 1'b0, beans_done = 1'b0;
   logic [2:0] state;
   logic       run, pos_reload, map_reload, over, win, flash;
   logic [1:0] lives;

   int checks = 0;
   int failures = 0;

   // Reference model: game phase number, lives, frames seen in the current phase
   int m_state, m_lives, m_cnt;
   bit m_prl, m_mrl;

   game_flow_ctrl #(.LIVES(NL), .READY_FRAMES(RF), .DEATH_FRAMES(DF)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
      .crash(crash), .beans_done(beans_done), .state(state), .run(run),
      .pos_reload(pos_reload), .map_reload(map_reload), .lives(lives),
      .over(over), .win(win), .flash(flash)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_lives = NL; m_cnt = 0; m_prl = 0; m_mrl = 0;
   endtask

   // Game rules applied to one sampled clock edge
   task automatic model_step(input bit s, input bit p, input bit c, input bit b, input bit t);
      int nxt;
      nxt = m_state; m_prl = 0; m_mrl = 0;
      case (m_state)
         0, 5, 6: if (s) begin nxt = 1; m_lives = NL; m_prl = 1; m_mrl = 1; end
         1: if (t && m_cnt == RF - 1) nxt = 2;
         2: begin
            if (b) nxt = 6;
            else if (c) begin nxt = 4; if (m_lives > 0) m_lives = m_lives - 1; end
            else if (p) nxt = 3;
         end
         3: if (p) nxt = 2;
         4: if (t && m_cnt == DF - 1) begin
               if (m_lives == 0) nxt = 5;
               else begin nxt = 1; m_prl = 1; end
            end
         default: nxt = 0;
      endcase
      if (nxt != m_state) m_cnt = 0;
      else if (t && m_state != 3) m_cnt = (m_cnt + 1) % 256;
      m_state = nxt;
   endtask

   task automatic compare_all();
      bit e_run, e_over, e_win, e_flash;
      e_run   = (m_state == 2);
      e_over  = (m_state == 5);
      e_win   = (m_state == 6);
      e_flash = (m_state == 1 || m_state == 4) && ((m_cnt / 8) % 2 == 1);
      checks++;
      if (int'(state) != m_state || run != e_run || pos_reload != m_prl || map_reload != m_mrl ||
          int'(lives) != m_lives || over != e_over || win != e_win || flash != e_flash) begin
         failures++;
         $display("FAIL model: got st=%0d run=%b prl=%b mrl=%b lives=%0d over=%b win=%b flash=%b expected st=%0d run=%b prl=%b mrl=%b lives=%0d over=%b win=%b flash=%b at %0t",
                  state, run, pos_reload, map_reload, lives, over, win, flash,
                  m_state, e_run, m_prl, m_mrl, m_lives, e_over, e_win, e_flash, $time);
      end
   endtask

   // One clock: drive at negedge, step model, compare at next negedge
   task automatic cyc(input bit s, input bit p, input bit c, input bit b, input bit t);
      start = s; pause = p; crash = c; beans_done = b; frame_tick = t;
      model_step(s, p, c, b, t);
      @(negedge clk);
      compare_all();
   endtask

   task automatic junk_idle();
      if ($urandom_range(0, 1) == 1)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   task automatic ready_to_play(input string tag);
      for (int i = 0; i < RF; i++) begin
         junk_idle();
         if (i == RF - 1) chk({tag, "_ready_hold"}, int'(state), 1);
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end
      chk({tag, "_play_state"}, int'(state), 2);
      chk({tag, "_play_run"}, int'(run), 1);
   endtask

   task automatic die(input int exp_lives);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("death_state", int'(state), 4);
      chk("death_lives", int'(lives), exp_lives);
      chk("death_run", int'(run), 0);
      for (int i = 0; i < DF; i++) begin
         junk_idle();
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1);
      end
   endtask

   task automatic async_reset();
      rst = 1'b0;
      #1;
      chk("async_state", int'(state), 0);
      chk("async_run", int'(run), 0);
      chk("async_lives", int'(lives), NL);
      chk("async_overwin", int'({over, win}), 0);
      model_reset();
      start = 0; pause = 0; crash = 0; beans_done = 0; frame_tick = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_state", int'(state), 0);
      chk("reset_lives", int'(lives), 3);
      compare_all();

      // Start from idle, then reach play
      cyc(1, 0, 0, 0, 0);
      chk("start_state", int'(state), 1);
      chk("start_reloads", int'({pos_reload, map_reload}), 3);
      cyc(0, 0, 0, 0, 0);
      chk("start_reload_drop", int'({pos_reload, map_reload}), 0);
      ready_to_play("first");

      // Simultaneous crash and beans_done wins with lives intact
      cyc(0, 0, 1, 1, 0);
      chk("win_state", int'(state), 6);
      chk("win_flag", int'(win), 1);
      chk("win_lives", int'(lives), 3);

      // Restart from win, then pause with crash held
      cyc(1, 0, 0, 0, 0);
      ready_to_play("second");
      cyc(0, 1, 0, 0, 0);
      chk("pause_state", int'(state), 3);
      chk("pause_run", int'(run), 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 1);
      chk("pause_hold", int'(state), 3);
      cyc(0, 1, 0, 0, 0);
      chk("unpause_state", int'(state), 2);

      // Three deaths to game over
      die(2);
      chk("respawn_reload", int'({pos_reload, map_reload}), 2);
      ready_to_play("life2");
      die(1);
      ready_to_play("life1");
      die(0);
      chk("over_state", int'(state), 5);
      chk("over_flag", int'(over), 1);
      chk("over_run", int'(run), 0);

      // Restart from over
      cyc(1, 0, 0, 0, 0);
      chk("restart_state", int'(state), 1);
      chk("restart_lives", int'(lives), 3);
      chk("restart_over", int'(over), 0);
      chk("restart_reloads", int'({pos_reload, map_reload}), 3);
      cyc(0, 0, 0, 0, 0);
      chk("restart_reload_drop", int'({pos_reload, map_reload}), 0);

      // Mid-play asynchronous reset
      ready_to_play("third");
      #2;
      async_reset();

      // Free-running random play
      for (int i = 0; i < 6000; i++) begin
         cyc(1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 3),
             1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 999) < 3),
             1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1999) == 0) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
